// File: rtl/filt_pkg.sv
// Shared types and constants for the filt1 line transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package filt_pkg;

    // Transmitter FSM; one-hot so that a corrupted register is detectable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_HOLD = 2'b10
    } filt_state_t;

    // Run length the receiving filter needs before it accepts a level.
    localparam int FILT_RUN     = 3;
    localparam int HOLD_DEFAULT = 4;

endpackage

// File: rtl/filt1_tx_if.sv
// Symbol handshake plus line-side outputs of the filt1 transmitter.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the slave gates each in_valid/in_data transfer.
interface filt1_tx_if;
    logic in_valid;
    logic in_data;
    logic in_ready;
    logic y;
    logic busy;
    logic done;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  y,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output y,
        output busy,
        output done
    );
endinterface

// File: rtl/filt1_tx.sv
// Drives each accepted symbol on y for HOLD cycles so a run-length filter receiver can see it.
// Latency: symbol accepted in cycle t is on y in cycles t+1..t+HOLD.
// Backpressure: in_ready only in IDLE or the last hold cycle; back-to-back symbols leave no gap.
module filt1_tx
    import filt_pkg::*;
#(
    parameter int   HOLD    = HOLD_DEFAULT,
    parameter logic RST_LVL = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    filt1_tx_if.slave bus
);

    localparam int              CW       = $clog2(HOLD);
    localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD - 1);

    // A hold shorter than the receiver's run length would be filtered away.
    generate
        if (HOLD < FILT_RUN || HOLD > 255) begin : g_bad_hold
            $error("filt1_tx: HOLD must lie in %0d..255", FILT_RUN);
        end
    endgenerate

    filt_state_t    r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_y;
    logic           r_busy;

    logic           w_last;
    logic           w_ready;
    logic           w_xfer;

    // Ready depends only on state and counter so it never loops back through in_valid.
    assign w_last  = (r_state == ST_HOLD) && (r_cnt == CNT_LAST);
    assign w_ready = (r_state == ST_IDLE) || w_last;
    assign w_xfer  = bus.in_valid && w_ready;

    assign bus.in_ready = w_ready;
    assign bus.done     = w_last;
    assign bus.y        = r_y;
    assign bus.busy     = r_busy;

    // FSM, hold counter and line register; y keeps its level in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_y     <= RST_LVL;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                        r_y     <= bus.in_data;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_xfer) begin
                        // Next symbol starts directly, no idle cycle on the line.
                        r_cnt <= '0;
                        r_y   <= bus.in_data;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    // Illegal encoding: recover to IDLE without disturbing the line.
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filt1_tx.sv
`timescale 1ns/1ps
module tb_filt1_tx;

    localparam int   H0 = 4;
    localparam int   H1 = 3;
    localparam logic L0 = 1'b0;
    localparam logic L1 = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    filt1_tx_if if0();
    filt1_tx_if if1();

    filt1_tx #(.HOLD(H0), .RST_LVL(L0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    filt1_tx #(.HOLD(H1), .RST_LVL(L1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: only the most recent accepted symbol and its acceptance cycle.
    bit   have     [2];
    int   last_t   [2];
    logic last_sym [2];

    // Loopback receiver model (3-sample run-length filter) and bookkeeping.
    logic [2:0] rx_hist;
    logic       rx_out;
    logic       ey_d1, ey_d2;
    int         rx_tr   = 0;
    int         sym_chg = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int hold_of(input int k);
        return (k == 0) ? H0 : H1;
    endfunction

    function automatic logic rlvl_of(input int k);
        return (k == 0) ? L0 : L1;
    endfunction

    function automatic logic m_y(input int k);
        return have[k] ? last_sym[k] : rlvl_of(k);
    endfunction

    function automatic logic m_busy(input int k);
        return have[k] && (cyc <= last_t[k] + hold_of(k));
    endfunction

    function automatic logic m_ready(input int k);
        return !have[k] || (cyc >= last_t[k] + hold_of(k));
    endfunction

    function automatic logic m_done(input int k);
        return have[k] && (cyc == last_t[k] + hold_of(k));
    endfunction

    // One clock cycle: drive, check at negedge, commit model at posedge.
    task automatic tick(input logic v0, input logic d0, input logic v1, input logic d1, input bit lb);
        bit x0, x1;
        if0.in_valid = v0;
        if0.in_data  = d0;
        if1.in_valid = v1;
        if1.in_data  = d1;
        @(negedge clk);
        chk("y0",     if0.y,        m_y(0));
        chk("busy0",  if0.busy,     m_busy(0));
        chk("ready0", if0.in_ready, m_ready(0));
        chk("done0",  if0.done,     m_done(0));
        chk("y1",     if1.y,        m_y(1));
        chk("busy1",  if1.busy,     m_busy(1));
        chk("ready1", if1.in_ready, m_ready(1));
        chk("done1",  if1.done,     m_done(1));
        if (lb) begin
            rx_hist = {rx_hist[1:0], if1.y};
            if (rx_hist == 3'b000 || rx_hist == 3'b111) begin
                if (rx_hist[0] !== rx_out) rx_tr++;
                rx_out = rx_hist[0];
            end
            chk("rx_lat2", rx_out, ey_d2);
            ey_d2 = ey_d1;
            ey_d1 = m_y(1);
        end
        x0 = v0 && m_ready(0);
        x1 = v1 && m_ready(1);
        if (lb && x1 && (d1 !== m_y(1))) sym_chg++;
        @(posedge clk);
        if (x0) begin have[0] = 1'b1; last_t[0] = cyc; last_sym[0] = d0; end
        if (x1) begin have[1] = 1'b1; last_t[1] = cyc; last_sym[1] = d1; end
        cyc++;
        #1;
    endtask

    task automatic idle0(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges, released after one edge.
    task automatic reset_mid();
        rst = 1'b1;
        #1;
        have[0] = 1'b0;
        have[1] = 1'b0;
        chk("rst_y0",     if0.y,        L0);
        chk("rst_busy0",  if0.busy,     1'b0);
        chk("rst_ready0", if0.in_ready, 1'b1);
        chk("rst_done0",  if0.done,     1'b0);
        chk("rst_y1",     if1.y,        L1);
        chk("rst_busy1",  if1.busy,     1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        rst          = 1'b1;
        if0.in_valid = 1'b0;
        if0.in_data  = 1'b0;
        if1.in_valid = 1'b0;
        if1.in_data  = 1'b0;
        have[0] = 1'b0;
        have[1] = 1'b0;
        last_t[0] = 0;
        last_t[1] = 0;
        last_sym[0] = 1'b0;
        last_sym[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("por_y0",     if0.y,        L0);
        chk("por_ready0", if0.in_ready, 1'b1);
        chk("por_y1",     if1.y,        L1);
        rst = 1'b0;
        cyc = 0;

        // Single symbol accepted at cycle 2, then idle.
        idle0(2);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle0(8);

        // Streaming 1,0,1 with in_valid held high.
        for (int i = 0; i < 12; i++) tick(1'b1, (i < 4 || i >= 8), 1'b0, 1'b0, 1'b0);
        idle0(3);

        // A 1 followed by two equal 0 symbols.
        for (int i = 0; i < 12; i++) tick(1'b1, (i < 4), 1'b0, 1'b0, 1'b0);
        idle0(3);

        // Idle gap between symbols, stray in_data toggling while idle.
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle0(3);
        for (int i = 0; i < 10; i++) tick(1'b0, i[0], 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle0(6);

        // Reset while transmitting 1 at cnt==2, then transfer right after release.
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle0(2);
        reset_mid();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle0(5);

        // Random traffic, in_valid dropping mid-hold and data churning.
        for (int i = 0; i < 400; i++)
            tick(($urandom_range(0, 9) < 7), 1'($urandom), 1'b0, 1'b0, 1'b0);
        idle0(5);

        // Loopback through a 3-sample filter with HOLD=3.
        reset_mid();
        rx_hist = {3{m_y(1)}};
        rx_out  = m_y(1);
        ey_d1   = m_y(1);
        ey_d2   = m_y(1);
        for (int i = 0; i < 300; i++)
            tick(1'b0, 1'b0, ($urandom_range(0, 9) < 8), 1'($urandom), 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rx_transitions", rx_tr, sym_chg);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
